// File: rtl/irq_pkg.sv
// Shared sizing and FSM encoding for the request-capture stage in front of the 16-to-4 encoder.
package irq_pkg;

  localparam int N      = 16;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLEAR = 2'd2
  } irq_state_t;

endpackage

// File: rtl/req_edge_det.sv
// Rising-edge detector for the raw request lines; req_prev tracks req_in even during reset.
module req_edge_det #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] req_in,
  output logic [DATA_W-1:0] rise
);

  logic [DATA_W-1:0] req_prev;

  // Loading during reset too means lines already high at release never look like new edges.
  always_ff @(posedge clk) begin
    req_prev <= req_in;
  end

  assign rise = rst ? '0 : (req_in & ~req_prev);

endmodule

// File: rtl/irq_pending_latch.sv
// Latches request edges into a pending register, masks them toward the external encoder,
// and serves the encoder's winning code through a single irq/ack handshake.
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  input  logic              mask_wr,
  input  logic [N-1:0]      mask_din,
  output logic [N-1:0]      mask_q,
  output logic [N-1:0]      pend_vec,
  input  logic [CODE_W-1:0] enc_code,
  output logic              irq,
  output logic [CODE_W-1:0] irq_code,
  input  logic              ack
);

  logic [N-1:0]      rise;
  logic [N-1:0]      pending;
  logic [N-1:0]      clr;
  logic              any;
  irq_state_t        state_q, state_d;
  logic              irq_d;
  logic [CODE_W-1:0] code_d;

  req_edge_det #(.DATA_W(N)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .req_in (req_in),
    .rise   (rise)
  );

  assign pend_vec = pending & mask_q;
  // The encoder reports 0 for both bit 0 and an empty vector, so qualify locally.
  assign any      = |pend_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask_q  <= '1;
    end else begin
      // A new edge on the bit being cleared wins, so the request is not lost.
      pending <= (pending & ~clr) | rise;
      if (mask_wr) begin
        mask_q <= mask_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      irq      <= 1'b0;
      irq_code <= '0;
    end else begin
      state_q  <= state_d;
      irq      <= irq_d;
      irq_code <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq;
    code_d  = irq_code;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (any) begin
          code_d  = enc_code;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // irq_code is frozen here, so later mask changes cannot redirect the clear.
        if (ack) begin
          clr[irq_code] = 1'b1;
          irq_d         = 1'b0;
          state_d       = CLEAR;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with a behavioural priority encoder and an irq_code scoreboard.
module tb_irq_pending_latch;
  import irq_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_in;
  logic              mask_wr;
  logic [N-1:0]      mask_din;
  logic [N-1:0]      mask_q;
  logic [N-1:0]      pend_vec;
  logic [CODE_W-1:0] enc_code;
  logic              irq;
  logic [CODE_W-1:0] irq_code;
  logic              ack;

  int checks = 0;
  int errors = 0;
  logic [CODE_W-1:0] expq[$];
  logic irq_seen = 1'b0;

  always #5 clk = ~clk;

  irq_pending_latch dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask_wr  (mask_wr),
    .mask_din (mask_din),
    .mask_q   (mask_q),
    .pend_vec (pend_vec),
    .enc_code (enc_code),
    .irq      (irq),
    .irq_code (irq_code),
    .ack      (ack)
  );

  // Highest set bit wins; empty input gives 0.
  always_comb begin
    enc_code = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_vec[i]) enc_code = CODE_W'(i);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every new irq assertion must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst && irq && !irq_seen) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_irq: got code %0d expected no irq", irq_code);
      end else begin
        logic [CODE_W-1:0] e;
        e = expq.pop_front();
        if (irq_code !== e) begin
          errors++;
          $display("FAIL sb_irq_code: got %0d expected %0d", irq_code, e);
        end
      end
    end
    irq_seen = irq;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_in = 16'h0001; mask_wr = 1'b0; mask_din = '0; ack = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_code", 32'(irq_code), 32'd0);
    chk("rst_pend", 32'(pend_vec), 32'h0);
    chk("rst_mask", 32'(mask_q), 32'hFFFF);
    req_in = 16'h0000;
    tick(2);

    // Single request on bit 5
    req_in = 16'h0020; expq.push_back(4'd5);
    tick();
    chk("b5_pend", 32'(pend_vec), 32'h0020);
    chk("b5_irq_early", 32'(irq), 32'd0);
    tick();
    chk("b5_irq", 32'(irq), 32'd1);
    chk("b5_code", 32'(irq_code), 32'd5);
    req_in = 16'h0000; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("b5_ack_irq", 32'(irq), 32'd0);
    chk("b5_ack_pend", 32'(pend_vec), 32'h0);
    tick(2);

    // Bits 3 and 12 together: 12 first, 3 after the bubble
    req_in = 16'h1008; expq.push_back(4'd12); expq.push_back(4'd3);
    tick(2);
    chk("dual_code12", 32'(irq_code), 32'd12);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("dual_ack_irq", 32'(irq), 32'd0);
    chk("dual_pend3", 32'(pend_vec), 32'h0008);
    tick();
    chk("dual_bubble", 32'(irq), 32'd0);
    tick();
    chk("dual_irq3", 32'(irq), 32'd1);
    chk("dual_code3", 32'(irq_code), 32'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0; req_in = 16'h0000;
    tick(2);

    // Masked request stays hidden; stray ack in IDLE is ignored
    mask_din = 16'hFFF7; mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
    chk("mask_q", 32'(mask_q), 32'hFFF7);
    req_in = 16'h0008;
    tick();
    chk("mask_pend", 32'(pend_vec), 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(2);
    chk("mask_no_irq", 32'(irq), 32'd0);
    expq.push_back(4'd3);
    mask_din = 16'hFFFF; mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
    chk("unmask_pend", 32'(pend_vec), 32'h0008);
    chk("unmask_irq_early", 32'(irq), 32'd0);
    tick();
    chk("unmask_irq", 32'(irq), 32'd1);
    chk("unmask_code", 32'(irq_code), 32'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0; req_in = 16'h0000;
    tick(2);

    // New edge on bit 7 coincident with ack: set wins
    req_in = 16'h0080; expq.push_back(4'd7);
    tick(2);
    chk("b7_code", 32'(irq_code), 32'd7);
    req_in = 16'h0000;
    tick();
    req_in = 16'h0080; ack = 1'b1; expq.push_back(4'd7);
    tick();
    ack = 1'b0;
    chk("b7_ack_irq", 32'(irq), 32'd0);
    chk("b7_still_pend", 32'(pend_vec), 32'h0080);
    tick();
    chk("b7_bubble", 32'(irq), 32'd0);
    tick();
    chk("b7_reirq", 32'(irq), 32'd1);
    chk("b7_recode", 32'(irq_code), 32'd7);
    req_in = 16'h0000; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("b7_clear_pend", 32'(pend_vec), 32'h0);
    tick(2);

    // Mask change in REQ holds irq; then reset mid-handshake
    req_in = 16'h4000; expq.push_back(4'd14);
    tick(2);
    chk("b14_code", 32'(irq_code), 32'd14);
    mask_din = 16'h00FF; mask_wr = 1'b1;
    tick();
    mask_wr = 1'b0;
    chk("hold_irq", 32'(irq), 32'd1);
    chk("hold_code", 32'(irq_code), 32'd14);
    chk("hold_mask", 32'(mask_q), 32'h00FF);
    rst = 1'b1; ack = 1'b1;
    tick();
    chk("mrst_irq", 32'(irq), 32'd0);
    chk("mrst_code", 32'(irq_code), 32'd0);
    chk("mrst_pend", 32'(pend_vec), 32'h0);
    chk("mrst_mask", 32'(mask_q), 32'hFFFF);
    rst = 1'b0; ack = 1'b0; req_in = 16'h0000;
    tick(4);
    chk("post_rst_irq", 32'(irq), 32'd0);
    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
